// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with redirects, stall hold, misalign trap and return-address stack
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   stall         hold pc and RAS this cycle
//   branch_taken  redirect to branch_target
//   branch_target branch destination
//   jump          redirect to jump_target
//   call          with jump, also push pc_plus_step onto the RAS
//   ret           pop the RAS (jump_target is the fallback when empty)
//   jump_target   jump/call destination, ret fallback
//   pc            current program counter (registered)
//   pc_plus_step  pc + STEP, combinational
//   misalign_trap one-cycle pulse: previous redirect target was misaligned
//   ras_overflow  one-cycle pulse: a push overwrote the oldest entry
//   ras_underflow one-cycle pulse: ret with an empty RAS
//   ras_count     number of valid RAS entries

module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int               ALIGN_BITS   = 2,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       jump,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           jump_target,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           pc_plus_step,
    output logic                       misalign_trap,
    output logic                       ras_overflow,
    output logic                       ras_underflow,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // A mask rather than a slice keeps ALIGN_BITS=0 legal: the mask is then
    // all-zero and no target can ever be flagged.
    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;

    logic [WIDTH-1:0] pc_next;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic             push;
    logic             trap_next;
    logic             ovf_next;
    logic             unf_next;

    assign pc_plus_step = pc + WIDTH'(STEP);

    always_comb begin
        pc_next   = pc_plus_step;
        ptr_next  = ras_ptr;
        cnt_next  = ras_count;
        target    = '0;
        redirect  = 1'b0;
        push      = 1'b0;
        trap_next = 1'b0;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;

        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            redirect = 1'b1;
            if (ras_count != '0) begin
                // ras_ptr always addresses the most recent push
                target   = ras_mem[ras_ptr];
                ptr_next = ras_ptr - 1'b1;
                cnt_next = ras_count - 1'b1;
            end else begin
                target   = jump_target;
                unf_next = 1'b1;
            end
        end else if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
            if (call) begin
                push     = 1'b1;
                ptr_next = ras_ptr + 1'b1;
                // A full stack is circular: the new entry lands on the oldest one.
                if (ras_count == CNT_W'(RAS_DEPTH)) begin
                    ovf_next = 1'b1;
                end else begin
                    cnt_next = ras_count + 1'b1;
                end
            end
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end

        // The RAS update above stands even when the target traps.
        if (redirect) begin
            if ((target & ALIGN_MASK) != '0) begin
                pc_next   = TRAP_VECTOR;
                trap_next = 1'b1;
            end else begin
                pc_next = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VECTOR;
            ras_ptr       <= '0;
            ras_count     <= '0;
            misalign_trap <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_ptr       <= ptr_next;
            ras_count     <= cnt_next;
            misalign_trap <= trap_next;
            ras_overflow  <= ovf_next;
            ras_underflow <= unf_next;
        end
    end

    // Entry contents need no reset; ras_count alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[ptr_next] <= pc_plus_step;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table and randomized reference-model bench for pc_sequencer

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic        misalign_trap;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [2:0]  ras_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .jump_target  (jump_target),
        .pc           (pc),
        .pc_plus_step (pc_plus_step),
        .misalign_trap(misalign_trap),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow),
        .ras_count    (ras_count)
    );

    typedef struct {
        logic        rst, stl, br;
        logic [31:0] bt;
        logic        jmp, cal, rt;
        logic [31:0] jt;
        logic [31:0] e_pc;
        int          e_cnt;
        logic        e_trap, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic cal, input logic rt, input logic [31:0] jt,
                                input logic [31:0] e_pc, input int e_cnt,
                                input logic e_trap, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.bt = bt;
        v.jmp = jmp; v.cal = cal; v.rt = rt; v.jt = jt;
        v.e_pc = e_pc; v.e_cnt = e_cnt;
        v.e_trap = e_trap; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    // Reference model: the RAS is an ordered list of return addresses,
    // newest at the back; overflow drops the front.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_trap, m_ovf, m_unf;

    task automatic model_step(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                              input logic jmp, input logic cal, input logic rt, input logic [31:0] jt);
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          redir;
        redir = 0;
        tgt   = '0;
        nxt   = m_pc + 32'd4;
        m_trap = 0; m_ovf = 0; m_unf = 0;
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
        end else if (!stl) begin
            if (rt) begin
                redir = 1;
                if (m_ras.size() > 0) tgt = m_ras.pop_back();
                else begin tgt = jt; m_unf = 1; end
            end else if (jmp) begin
                redir = 1;
                tgt = jt;
                if (cal) begin
                    if (m_ras.size() == 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                    m_ras.push_back(nxt);
                end
            end else if (br) begin
                redir = 1;
                tgt = bt;
            end
            if (redir) begin
                if (tgt % 4 != 0) begin m_pc = 32'h100; m_trap = 1; end
                else m_pc = tgt;
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] e_pc, input int e_cnt,
                         input logic e_trap, input logic e_ovf, input logic e_unf);
        logic [31:0] e_pps;
        e_pps = e_pc + 32'd4;
        n_vec++;
        if (pc !== e_pc || pc_plus_step !== e_pps || int'(ras_count) != e_cnt ||
            misalign_trap !== e_trap || ras_overflow !== e_ovf || ras_underflow !== e_unf) begin
            n_fail++;
            $display("FAIL %s: got pc=%h pps=%h cnt=%0d trap=%b ovf=%b unf=%b, need pc=%h pps=%h cnt=%0d trap=%b ovf=%b unf=%b",
                     name, pc, pc_plus_step, ras_count, misalign_trap, ras_overflow, ras_underflow,
                     e_pc, e_pps, e_cnt, e_trap, e_ovf, e_unf);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic cal, input logic rt, input logic [31:0] jt);
        reset = rst; stall = stl; branch_taken = br; branch_target = bt;
        jump = jmp; call = cal; ret = rt; jump_target = jt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset and free run
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,            32'h0,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h4,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h8,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'hC,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h10,  0, 0,0,0));
        // call then return
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h200,      32'h200, 1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h14,  0, 0,0,0));
        // five nested calls from 0x0
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,            32'h0,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h100,      32'h100, 1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h200,      32'h200, 2, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h300,      32'h300, 3, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h400,      32'h400, 4, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h500,      32'h500, 4, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h404, 3, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h304, 2, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h204, 1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h104, 0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,32'h80,       32'h80,  0, 0,0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h84,  0, 0,0,0));
        // misaligned branch
        vecs.push_back(mk(0,0,1,32'h302, 0,0,0,0,      32'h100, 0, 1,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h104, 0, 0,0,0));
        // stall with pending jump
        vecs.push_back(mk(0,1,0,0, 1,0,0,32'h600,      32'h104, 0, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,0,0,32'h600,      32'h104, 0, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,0,0,32'h600,      32'h104, 0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,0,0,32'h600,      32'h600, 0, 0,0,0));
        // misaligned call still pushes
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h602,      32'h100, 1, 1,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,0,            32'h604, 0, 0,0,0));
        // wrap-around
        vecs.push_back(mk(0,0,0,0, 1,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,            32'h0,   0, 0,0,0));
        // reset mid-call sequence
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h700,      32'h700, 1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h800,      32'h800, 2, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,32'h900,      32'h0,   0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,1,32'h40,       32'h40,  0, 0,0,1));
        // call without jump, ret over jump, jump over branch
        vecs.push_back(mk(0,0,0,0, 0,1,0,32'h500,      32'h44,  0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0,32'h1000,     32'h1000,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,0,1,32'h2000,     32'h48,  0, 0,0,0));
        vecs.push_back(mk(0,0,1,32'h4000, 1,0,0,32'h3000, 32'h3000, 0, 0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].bt,
                  vecs[i].jmp, vecs[i].cal, vecs[i].rt, vecs[i].jt);
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                  vecs[i].e_trap, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // randomized phase against the reference model
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("rand_reset", m_pc, m_ras.size(), m_trap, m_ovf, m_unf);
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_stl, r_br, r_jmp, r_cal, r_rt;
            logic [31:0] r_bt, r_jt;
            r_rst = ($urandom_range(0, 99) == 0);
            r_stl = ($urandom_range(0, 7) == 0);
            r_br  = ($urandom_range(0, 4) == 0);
            r_jmp = ($urandom_range(0, 3) == 0);
            r_cal = ($urandom_range(0, 1) == 0);
            r_rt  = ($urandom_range(0, 4) == 0);
            r_bt  = (32'($urandom_range(0, 1023)) << 2) |
                    (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            r_jt  = (32'($urandom_range(0, 1023)) << 2) |
                    (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            model_step(r_rst, r_stl, r_br, r_bt, r_jmp, r_cal, r_rt, r_jt);
            drive(r_rst, r_stl, r_br, r_bt, r_jmp, r_cal, r_rt, r_jt);
            check($sformatf("rand%0d", i), m_pc, m_ras.size(), m_trap, m_ovf, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the monocycle core. It replaces the fixed "PC + 4" incrementer with a registered PC that also handles branch, jump, call and return redirects, pipeline stall hold and misaligned-target trapping. Return addresses are held in a small circular return-address stack (RAS). It sits between the control unit and the instruction memory address port.

Parameters:
- WIDTH, 32, PC and target width in bits.
- STEP, 4, sequential increment added to the PC each cycle.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded when a redirect target is misaligned.
- ALIGN_BITS, 2, number of target LSBs that must be zero.
- RAS_DEPTH, 4, number of RAS entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS unchanged this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  unconditional jump.
- call  in  1  jump that also pushes the return address; only meaningful with jump=1.
- ret  in  1  return: pop the RAS.
- jump_target  in  WIDTH  jump/call destination; also the fallback target for ret on an empty RAS.
- pc  out  WIDTH  current PC (registered).
- pc_plus_step  out  WIDTH  pc + STEP, combinational, wraps modulo 2^WIDTH.
- misalign_trap  out  1  one-cycle registered pulse: the previous redirect was misaligned.
- ras_overflow  out  1  one-cycle registered pulse: a push overwrote the oldest entry.
- ras_underflow  out  1  one-cycle registered pulse: ret occurred with an empty RAS.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.

Behaviour:
- reset=1 at a rising edge sets:
  - pc = RESET_VECTOR;
  - ras_count = 0 and RAS pointer = 0 (entry contents don't care);
  - misalign_trap = ras_overflow = ras_underflow = 0.
- reset overrides every other input.
- Next-PC priority, evaluated each edge when reset=0:
  1. stall: pc, RAS, pointer and ras_count hold; all pulse outputs go to 0.
  2. ret: if ras_count>0, target = RAS[top], pointer decrements (wraps) and ras_count decrements. If ras_count=0, target = jump_target and ras_underflow=1 for one cycle.
  3. jump: target = jump_target. If call=1, pc_plus_step is pushed: write at pointer+1 (wraps) and pointer advances. If ras_count=RAS_DEPTH, the oldest entry is overwritten, ras_count stays at RAS_DEPTH and ras_overflow=1 for one cycle; otherwise ras_count increments.
  4. branch_taken: target = branch_target.
  5. Otherwise: pc = pc + STEP, with wrap-around modulo 2^WIDTH and no flag.
- Lower-priority requests in the same cycle are ignored, e.g. ret+jump performs ret only.
- Alignment check applies only to redirect targets (steps 2-4):
  - if target[ALIGN_BITS-1:0] != 0, pc = TRAP_VECTOR and misalign_trap=1 for one cycle;
  - the RAS push/pop of that cycle still takes effect;
  - with ALIGN_BITS=0 the check is disabled.
- call without jump has no effect.
- Latency: one cycle from inputs to pc; pc_plus_step follows pc combinationally.
- Pulse outputs are 0 in any cycle that does not raise them.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0x0, 0x4, 0x8, 0xC; pc_plus_step = pc+4; all flags 0.
- At pc=0x10, jump=1, call=1, jump_target=0x200 -> pc=0x200, ras_count=1. Next cycle ret=1 -> pc=0x14, ras_count=0.
- Five nested calls with RAS_DEPTH=4 (from pc 0x0, 0x100, 0x200, 0x300, 0x400):
  - 5th call -> ras_overflow pulses once, ras_count stays 4;
  - four rets -> pc = 0x404, 0x304, 0x204, 0x104;
  - fifth ret with jump_target=0x80 -> pc=0x80, ras_underflow=1.
- branch_taken=1, branch_target=0x302 -> pc=0x100 (TRAP_VECTOR), misalign_trap=1 for exactly one cycle, then pc=0x104.
- stall=1 held for 3 cycles with jump=1 asserted -> pc and ras_count unchanged. Stall released with jump still asserted -> jump taken.
- pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000. Assert reset mid-call sequence (ras_count=2) -> pc=0x0, ras_count=0 on the next edge.
